// File: rtl/bit_deser.sv
// Serial-to-parallel receiver: 1 start, 8 data bits LSB-first, 1 stop, one bit per CLK, with a one-byte valid/ready buffer.
// Define BIT_DESER_PARITY_EN to add an even-parity bit after the data bits; without it PERR is tied low.
module bit_deser (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SIN,
    output logic [7:0] DOUT,
    output logic       DVALID,
    input  logic       DREADY,
    output logic       PERR,
    output logic       FERR,
    output logic       OVR,
    input  logic       OVR_CLR
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
`ifdef BIT_DESER_PARITY_EN
        ST_PAR   = 3'd2,
`endif
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

`ifdef BIT_DESER_PARITY_EN
    function automatic logic parity_error(input logic [7:0] data, input logic par_bit);
        return ^{data, par_bit};
    endfunction

    localparam state_t ST_AFTER_DATA = ST_PAR;
`else
    localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] dout_q, dout_d;
    logic       dvalid_q, dvalid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       frame_good_s;
    logic       ovr_set_s;
`ifdef BIT_DESER_PARITY_EN
    logic       par_err_q, par_err_d;
    logic       perr_q, perr_d;
`endif

    // Receive FSM next state plus output-buffer and overrun next state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        ferr_d       = 1'b0;
        frame_good_s = 1'b0;
`ifdef BIT_DESER_PARITY_EN
        par_err_d    = par_err_q;
        perr_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!SIN) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                shift_d[cnt_q] = SIN;
                if (cnt_q == 3'd7) begin
                    state_d = ST_AFTER_DATA;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                end
            end
`ifdef BIT_DESER_PARITY_EN
            ST_PAR: begin
                par_err_d = parity_error(shift_q, SIN);
                state_d   = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (SIN) begin
                    state_d = ST_IDLE;
`ifdef BIT_DESER_PARITY_EN
                    if (par_err_q) begin
                        perr_d = 1'b1;
                    end else begin
                        frame_good_s = 1'b1;
                    end
`else
                    frame_good_s = 1'b1;
`endif
                end else begin
                    // Low stop bit is a framing error; wait out the break before hunting for a start.
                    state_d = ST_BREAK;
                    ferr_d  = 1'b1;
                end
            end
            ST_BREAK: begin
                if (SIN) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        dout_d    = dout_q;
        dvalid_d  = dvalid_q;
        ovr_set_s = 1'b0;
        if (frame_good_s) begin
            if (!dvalid_q || DREADY) begin
                dout_d   = shift_q;
                dvalid_d = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else if (dvalid_q && DREADY) begin
            dvalid_d = 1'b0;
        end else begin
            dvalid_d = dvalid_q;
        end

        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (OVR_CLR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            shift_q   <= 8'h00;
            dout_q    <= 8'h00;
            dvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef BIT_DESER_PARITY_EN
            par_err_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef BIT_DESER_PARITY_EN
            par_err_q <= par_err_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign FERR   = ferr_q;
    assign OVR    = ovr_q;
`ifdef BIT_DESER_PARITY_EN
    assign PERR   = perr_q;
`else
    assign PERR   = 1'b0;
`endif

endmodule
